multi_pwm: RTL
==============

Name: multi_pwm

Overview:
Parametrised multi-channel successor to the single-channel PWM. It has one shared timebase with a programmable prescaler and period, and supports edge-aligned and center-aligned counting. Each of CH channels has its own compare (duty) register. Duty, period and mode are double-buffered and take effect only at frame boundaries, so outputs never glitch mid-frame. It sits between the register/control logic and the pads or motor drivers.

Parameters:
R, 8, counter width in bits; period range 0..2^R-1
CH, 4, number of PWM channels
PRESC_W, 8, prescaler width in bits

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  timebase run; 0 = hold counter and force outputs low
prescale  input  PRESC_W  counter advances once every prescale+1 clk cycles; not shadowed
period_in  input  R  frame terminal count
center_in  input  1  0 = edge-aligned, 1 = center-aligned
duty_in  input  CH*(R+1)  packed per-channel duty; channel i at [i*(R+1) +: R+1]
update  input  1  one-clk strobe that captures period_in, center_in and duty_in into the shadow registers
pwm_out  output  CH  registered PWM outputs
period_end  output  1  one-clk pulse on each frame-boundary tick
pending  output  1  shadow registers hold values not yet applied

Behaviour:
- Reset values:
  - counters and direction: presc_cnt=0, cnt=0, dir=up.
  - active/shadow: duty=0 on all channels; period=2^R-1; center=0.
  - outputs: pwm_out=0, period_end=0, pending=0.
- Prescaler:
  - tick is asserted when presc_cnt==prescale; presc_cnt then returns to 0, otherwise it increments.
  - prescale=0 gives a tick every clk.
  - If prescale changes below the current presc_cnt, presc_cnt wraps through 2^PRESC_W-1 back to 0; there is no lock-up.
- Edge mode (counts only on tick):
  - cnt runs 0,1,...,period,0,...
  - Boundary tick is the tick with cnt==period. Frame length is period+1 ticks.
- Center mode (counts only on tick):
  - cnt runs 0 up to period, then period-1 down to 0, then repeats; dir flips on reaching period and on reaching 0.
  - Boundary tick is the tick that moves cnt to 0 (dir down, cnt==1). Frame length is 2*period ticks.
- period=0: cnt stays 0 and every tick is a boundary tick, in both modes.
- Compare:
  - pwm_out[i] <= enable & (cnt < duty_act[i]), registered. Latency is 1 clk from cnt.
  - duty=0 gives constant low. duty >= period+1 gives constant high; duty is R+1 bits so 100% is reachable with period=2^R-1.
  - Center mode gives a symmetric pulse around cnt==0 of width 2*duty-1 ticks (clamped to the full frame).
- Double buffering:
  - update loads the shadow registers and sets pending.
  - On a boundary tick with pending=1: active <= shadow and pending clears, in the same clk.
  - The new values take effect from the following cnt.
  - A mode change resets dir to up and cnt to 0 at the boundary.
- Simultaneous update and boundary tick: the shadow takes the new values, pending stays 1, and the transfer happens at the next boundary. Values captured earlier are overwritten and are never applied.
- period_end pulses for one clk on every boundary tick, whether or not a transfer occurs.
- enable=0:
  - presc_cnt=0, cnt=0, dir=up, pwm_out=0, period_end=0.
  - If pending=1, the transfer happens immediately on the next clk.
  - On re-enable, counting restarts from 0 with the active values.
- reset mid-frame: all state returns to its reset values on the next clk edge. A concurrent update is ignored.

Optional Feature:
Macro PWM_POLARITY_EN.
- Defined: adds input port polarity[CH-1:0], which is shadowed together with duty. A channel with active polarity=1 outputs ~compare while enabled; while disabled, that channel's output rests at 1, so the output idles inactive. polarity resets to 0.
- Undefined: no polarity port; all outputs are active-high and idle low.

Decomposition:
- Package pwm_pkg:
  - MODE_EDGE=1'b0, MODE_CENTER=1'b1.
  - Default widths R_DEF=8, CH_DEF=4, PRESC_W_DEF=8.
  - A function returning the channel slice offset i*(R+1).
- Sub-module pwm_timebase (prescaler, cnt, dir, boundary detect): outputs cnt, tick, boundary.
- Per-channel compare and shadow logic live in a generate loop in multi_pwm.

Test Plan:
- Reset, then update with period=9, center=0, duty ch0..3 = 0,3,10,5, prescale=0, enable=1 -> ch0 always 0; ch1 high 3 of every 10 clk; ch2 always 1; ch3 high 5/10; period_end every 10 clk.
- prescale=3, period=4, duty=2 -> each frame lasts 20 clk with 8 clk high; period_end spacing is 20 clk.
- Center mode, period=4, duty=2 -> frame of 8 ticks; output high at cnt 0 and at cnt 1 on both the up and down slopes (3 ticks), symmetric.
- Mid-frame update with duty 3->7 -> old duty holds until the boundary; pending=1 until period_end, then the new duty appears in the next frame. Update issued in the same clk as a boundary -> applied one frame later.
- Mid-frame enable=0 with pending=1 -> pwm_out=0 next clk, cnt=0, pending clears; on re-enable the first frame uses the new values.
- Assert reset mid-frame together with update -> all outputs and state at reset values; pending=0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants, types and helpers for the multi-channel PWM.
// Optional per-channel output polarity is enabled with macro PWM_POLARITY_EN.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    localparam int unsigned R_DEF       = 32'd8;
    localparam int unsigned CH_DEF      = 32'd4;
    localparam int unsigned PRESC_W_DEF = 32'd8;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Bit offset of a channel's duty field inside the packed duty bus.
    function automatic int unsigned ch_offset(input int unsigned idx, input int unsigned r_w);
        return idx * (r_w + 32'd1);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, up/up-down frame counter and frame-boundary detect.
// The count direction is a two-state machine (state reg / next-state / output logic).
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned R       = R_DEF,
    parameter int unsigned PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [R-1:0]       period,
    input  logic               center,
    output logic [R-1:0]       cnt,
    output logic               tick,
    output logic               boundary
);

    localparam logic [R-1:0]       CNT_ZERO   = {R{1'b0}};
    localparam logic [R-1:0]       CNT_ONE    = {{(R-1){1'b0}}, 1'b1};
    localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
    localparam logic [PRESC_W-1:0] PRESC_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};

    logic [PRESC_W-1:0] r_presc_cnt;
    logic [PRESC_W-1:0] w_presc_nxt;
    logic [R-1:0]       r_cnt;
    logic [R-1:0]       w_cnt_nxt;
    dir_e               r_dir;
    dir_e               w_dir_nxt;
    logic               w_tick;
    logic               w_at_end;
    logic               w_boundary;

    // Tick and frame-end detection from the current counter state
    always_comb begin
        w_tick = enable & (r_presc_cnt == prescale);
        if (period == CNT_ZERO) begin
            w_at_end = 1'b1;
        end else if (center == MODE_CENTER) begin
            w_at_end = (r_dir == DIR_DOWN) && (r_cnt == CNT_ONE);
        end else begin
            w_at_end = (r_cnt >= period);
        end
        w_boundary = w_tick & w_at_end;
    end

    // Next prescaler, count and direction
    always_comb begin
        w_presc_nxt = r_presc_cnt;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        if (!enable) begin
            w_presc_nxt = PRESC_ZERO;
            w_cnt_nxt   = CNT_ZERO;
            w_dir_nxt   = DIR_UP;
        end else if (!w_tick) begin
            // Free-running increment also recovers when prescale drops below the count.
            w_presc_nxt = r_presc_cnt + PRESC_ONE;
        end else if (w_boundary) begin
            // Every frame restarts at zero counting up, which also covers mode changes.
            w_presc_nxt = PRESC_ZERO;
            w_cnt_nxt   = CNT_ZERO;
            w_dir_nxt   = DIR_UP;
        end else if (center == MODE_EDGE) begin
            w_presc_nxt = PRESC_ZERO;
            w_cnt_nxt   = r_cnt + CNT_ONE;
            w_dir_nxt   = DIR_UP;
        end else begin
            w_presc_nxt = PRESC_ZERO;
            case (r_dir)
                DIR_UP: begin
                    if (r_cnt >= period) begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                        w_dir_nxt = DIR_DOWN;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                        w_dir_nxt = ((r_cnt + CNT_ONE) == period) ? DIR_DOWN : DIR_UP;
                    end
                end
                DIR_DOWN: begin
                    if (r_cnt == CNT_ZERO) begin
                        w_cnt_nxt = CNT_ZERO;
                        w_dir_nxt = DIR_UP;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                        w_dir_nxt = DIR_DOWN;
                    end
                end
                default: begin
                    w_cnt_nxt = CNT_ZERO;
                    w_dir_nxt = DIR_UP;
                end
            endcase
        end
    end

    // Timebase state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc_cnt <= PRESC_ZERO;
            r_cnt       <= CNT_ZERO;
            r_dir       <= DIR_UP;
        end else begin
            r_presc_cnt <= w_presc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dir       <= w_dir_nxt;
        end
    end

    assign cnt      = r_cnt;
    assign tick     = w_tick;
    assign boundary = w_boundary;

endmodule

// File: rtl/multi_pwm.sv
// Multi-channel PWM with shared timebase and frame-synchronous double-buffered settings.
// Define PWM_POLARITY_EN to add a shadowed per-channel output polarity input.
module multi_pwm
    import pwm_pkg::*;
#(
    parameter int unsigned R       = R_DEF,
    parameter int unsigned CH      = CH_DEF,
    parameter int unsigned PRESC_W = PRESC_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PRESC_W-1:0]  prescale,
    input  logic [R-1:0]        period_in,
    input  logic                center_in,
    input  logic [CH*(R+1)-1:0] duty_in,
    input  logic                update,
`ifdef PWM_POLARITY_EN
    input  logic [CH-1:0]       polarity,
`endif
    output logic [CH-1:0]       pwm_out,
    output logic                period_end,
    output logic                pending
);

    localparam logic [R-1:0] PERIOD_RST = {R{1'b1}};

    logic [R-1:0]  r_period_sh;
    logic [R-1:0]  r_period_act;
    logic          r_center_sh;
    logic          r_center_act;
    logic          r_pending;
    logic          r_period_end;
    logic [CH-1:0] r_pwm_out;

    logic [R-1:0]  w_cnt;
    logic          w_tick;
    logic          w_boundary;
    logic          w_frame_end;
    logic          w_xfer;
    logic [CH-1:0] w_cmp;
    logic [CH-1:0] w_idle;

    pwm_timebase #(
        .R       (R),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .prescale (prescale),
        .period   (r_period_act),
        .center   (r_center_act),
        .cnt      (w_cnt),
        .tick     (w_tick),
        .boundary (w_boundary)
    );

    // Shadow-to-active transfer: at a frame end or while stopped, unless a new capture is arriving
    always_comb begin
        w_frame_end = w_tick & w_boundary;
        if (update) begin
            w_xfer = 1'b0;
        end else if (r_pending) begin
            w_xfer = w_frame_end | ~enable;
        end else begin
            w_xfer = 1'b0;
        end
    end

    // Shared shadow/active period and mode, plus the pending flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period_sh  <= PERIOD_RST;
            r_period_act <= PERIOD_RST;
            r_center_sh  <= MODE_EDGE;
            r_center_act <= MODE_EDGE;
            r_pending    <= 1'b0;
        end else if (update) begin
            r_period_sh <= period_in;
            r_center_sh <= center_in;
            r_pending   <= 1'b1;
        end else if (w_xfer) begin
            r_period_act <= r_period_sh;
            r_center_act <= r_center_sh;
            r_pending    <= 1'b0;
        end else begin
            r_pending <= r_pending;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        localparam int unsigned OFF = ch_offset(g, R);

        logic [R:0] r_duty_sh;
        logic [R:0] r_duty_act;
        logic       w_hit;

        // Per-channel duty double buffer
        always_ff @(posedge clk) begin
            if (reset) begin
                r_duty_sh  <= {(R+1){1'b0}};
                r_duty_act <= {(R+1){1'b0}};
            end else begin
                if (update) begin
                    r_duty_sh <= duty_in[OFF +: R+1];
                end
                if (w_xfer) begin
                    r_duty_act <= r_duty_sh;
                end
            end
        end

        // Duty is one bit wider than the count so that 100% is reachable at full period.
        assign w_hit = ({1'b0, w_cnt} < r_duty_act);

`ifdef PWM_POLARITY_EN
        logic r_pol_sh;
        logic r_pol_act;

        // Per-channel polarity double buffer, moves together with duty
        always_ff @(posedge clk) begin
            if (reset) begin
                r_pol_sh  <= 1'b0;
                r_pol_act <= 1'b0;
            end else begin
                if (update) begin
                    r_pol_sh <= polarity[g];
                end
                if (w_xfer) begin
                    r_pol_act <= r_pol_sh;
                end
            end
        end

        assign w_cmp[g]  = w_hit ^ r_pol_act;
        assign w_idle[g] = r_pol_act;
`else
        assign w_cmp[g]  = w_hit;
        assign w_idle[g] = 1'b0;
`endif
    end

    // Registered channel outputs and frame-end pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_out    <= {CH{1'b0}};
            r_period_end <= 1'b0;
        end else begin
            r_pwm_out    <= enable ? w_cmp : w_idle;
            r_period_end <= w_frame_end;
        end
    end

    assign pwm_out    = r_pwm_out;
    assign period_end = r_period_end;
    assign pending    = r_pending;

endmodule
